// File: rtl/tt_sweep.sv
// Truth-table sweeper: walks every input vector of a small combinational DUT,
// captures its output and compares against a golden table. Optional macro: TT_SWEEP_STOP_ON_ERR_EN.
`timescale 1ns/1ps
module tt_sweep #(
  parameter int NIN  = 4,
  parameter int HOLD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [(1<<NIN)-1:0]  expected,
  input  logic                 y,
  output logic [NIN-1:0]       vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NIN:0]         err_count,
  output logic [NIN-1:0]       first_err_idx,
  output logic [(1<<NIN)-1:0]  captured
);

  localparam int NV = 1 << NIN;
  localparam logic [7:0]     HOLD_LAST = 8'(HOLD - 1);
  localparam logic [NIN-1:0] VEC_LAST  = {NIN{1'b1}};

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t         state, state_next;
  logic [NV-1:0]  exp_q;
  logic [7:0]     hold_cnt;
  logic           sample, mismatch, last_vec, finish;
  logic [NIN:0]   err_next;

  always_comb begin
    state_next = state;
    sample     = (state == DRIVE) && (hold_cnt == HOLD_LAST);
    mismatch   = sample && (y != exp_q[vec]);
    last_vec   = (vec == VEC_LAST);
    err_next   = err_count + {{NIN{1'b0}}, mismatch};
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE: begin
`ifdef TT_SWEEP_STOP_ON_ERR_EN
        if (sample && (last_vec || mismatch)) state_next = DONE;
`else
        if (sample && last_vec) state_next = DONE;
`endif
      end
      default: state_next = IDLE;
    endcase
    finish = (state == DRIVE) && (state_next == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      exp_q         <= '0;
      hold_cnt      <= '0;
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      captured      <= '0;
    end else begin
      state <= state_next;
      if (state != DRIVE && start) begin
        // Table is latched here so later edits to expected cannot disturb the sweep.
        exp_q         <= expected;
        captured      <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
        vec           <= '0;
        hold_cnt      <= '0;
        busy          <= 1'b1;
        done          <= 1'b0;
        pass          <= 1'b0;
      end else if (state == DRIVE) begin
        if (sample) begin
          hold_cnt      <= '0;
          captured[vec] <= y;
          err_count     <= err_next;
          // err_count is still zero only until the first mismatch of this sweep.
          if (mismatch && err_count == '0) first_err_idx <= vec;
          if (finish) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_next == '0);
          end else begin
            vec <= vec + 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

endmodule
